// File: rtl/kronos_fetch_queue.sv
// Kronos RV32I fetch front end: sequential fetch into a DEPTH-entry {pc, ir} prefetch queue with branch flush.
// Optional macro KRONOS_FETCH_BYPASS_EN lets a word granted into an empty queue reach decode in the same cycle.
module kronos_fetch_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter logic [31:0] PC_INC    = 32'd4
) (
    input  logic                       clk,
    input  logic                       rstz,
    output logic [31:0]                instr_addr,
    input  logic [31:0]                instr_data,
    output logic                       instr_req,
    input  logic                       instr_gnt,
    input  logic                       branch,
    input  logic [31:0]                branch_target,
    output logic [31:0]                fetch_pc,
    output logic [31:0]                fetch_ir,
    output logic                       pipe_out_vld,
    input  logic                       pipe_out_rdy,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   ir_mem_q [DEPTH];

    logic full, empty, push, write_en, pop_mem;
    logic [1:0] unused_tgt_bits;

    assign unused_tgt_bits = branch_target[1:0];

    assign full  = (occ_q == OW'(DEPTH));
    assign empty = (occ_q == '0);

    // Reset gates the request so a grant arriving during reset is never taken.
    assign instr_req  = !rstz && !full && !branch;
    assign instr_addr = pc_q;
    assign push       = instr_req && instr_gnt;
    assign occupancy  = occ_q;

`ifdef KRONOS_FETCH_BYPASS_EN
    logic bypass_take;
    assign bypass_take  = empty && push && pipe_out_rdy;
    assign pipe_out_vld = !empty || push;
    assign fetch_pc     = empty ? pc_q : pc_mem_q[rd_ptr_q];
    assign fetch_ir     = empty ? instr_data : ir_mem_q[rd_ptr_q];
    assign write_en     = push && !bypass_take;
`else
    assign pipe_out_vld = !empty;
    assign fetch_pc     = pc_mem_q[rd_ptr_q];
    assign fetch_ir     = ir_mem_q[rd_ptr_q];
    assign write_en     = push;
`endif

    assign pop_mem = !empty && pipe_out_rdy && !branch;

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (branch) begin
            pc_d     = {branch_target[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                pc_d = pc_q + PC_INC;
            end
            if (write_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_mem) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({write_en, pop_mem})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstz) begin
        if (rstz) begin
            pc_q     <= BOOT_ADDR;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is cleared on reset so the head outputs read zero before the first fetch.
    always_ff @(posedge clk or posedge rstz) begin
        if (rstz) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i] <= '0;
                ir_mem_q[i] <= '0;
            end
        end else if (write_en && !branch) begin
            pc_mem_q[wr_ptr_q] <= pc_q;
            ir_mem_q[wr_ptr_q] <= instr_data;
        end
    end

endmodule

// File: tb/tb_kronos_fetch_queue.sv
// Self-checking bench for kronos_fetch_queue (default build): directed steps plus random traffic against a queue model.
module tb_kronos_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rstz;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        instr_req;
    logic        instr_gnt;
    logic        branch;
    logic [31:0] branch_target;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_ir;
    logic        pipe_out_vld;
    logic        pipe_out_rdy;
    logic [$clog2(DEPTH):0] occupancy;

    int testCount = 0;
    int failCount = 0;

    // Reference model: an unbounded queue of {pc, ir} limited to DEPTH by the request rule.
    logic [31:0] modelPc;
    logic [31:0] qPc[$];
    logic [31:0] qIr[$];

    kronos_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rstz(rstz),
        .instr_addr(instr_addr),
        .instr_data(instr_data),
        .instr_req(instr_req),
        .instr_gnt(instr_gnt),
        .branch(branch),
        .branch_target(branch_target),
        .fetch_pc(fetch_pc),
        .fetch_ir(fetch_ir),
        .pipe_out_vld(pipe_out_vld),
        .pipe_out_rdy(pipe_out_rdy),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive at the negedge, check 1ns later, advance the model, wait for the next negedge.
    task automatic applyStimulus(input logic g, input logic r, input logic b, input logic [31:0] tgt);
        logic expReq;
        instr_gnt     = g;
        pipe_out_rdy  = r;
        branch        = b;
        branch_target = tgt;
        instr_data    = $urandom;
        #1;
        expReq = (qPc.size() < DEPTH) && !b;
        checkOutput("instr_req", 32'(instr_req), 32'(expReq));
        checkOutput("instr_addr", instr_addr, modelPc);
        checkOutput("pipe_out_vld", 32'(pipe_out_vld), 32'(qPc.size() != 0));
        checkOutput("occupancy", 32'(occupancy), 32'(qPc.size()));
        if (qPc.size() != 0) begin
            checkOutput("fetch_pc", fetch_pc, qPc[0]);
            checkOutput("fetch_ir", fetch_ir, qIr[0]);
        end
        if (b) begin
            qPc.delete();
            qIr.delete();
            modelPc = {tgt[31:2], 2'b00};
        end else begin
            if (qPc.size() != 0 && r) begin
                void'(qPc.pop_front());
                void'(qIr.pop_front());
            end
            if (expReq && g) begin
                qPc.push_back(modelPc);
                qIr.push_back(instr_data);
                modelPc = modelPc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic checkReset();
        checkOutput("rst_req", 32'(instr_req), 32'd0);
        checkOutput("rst_vld", 32'(pipe_out_vld), 32'd0);
        checkOutput("rst_occ", 32'(occupancy), 32'd0);
        checkOutput("rst_fetch_pc", fetch_pc, 32'd0);
        checkOutput("rst_fetch_ir", fetch_ir, 32'd0);
        checkOutput("rst_addr", instr_addr, 32'd0);
    endtask

    initial begin
        rstz          = 1'b1;
        instr_gnt     = 1'b1;
        pipe_out_rdy  = 1'b1;
        branch        = 1'b0;
        branch_target = '0;
        instr_data    = '0;
        modelPc       = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkReset();
        rstz = 1'b0;

        // Streaming with gnt and rdy tied high.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Fill to full with decode stalled, then drain.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("full_req_low", 32'(instr_req), 32'd0);
        checkOutput("full_occ", 32'(occupancy), 32'(DEPTH));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

        // Branch while full with a grant in the same cycle.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        #1;
        checkOutput("branch_addr", instr_addr, 32'h0000_0100);
        checkOutput("branch_vld", 32'(pipe_out_vld), 32'd0);
        checkOutput("branch_occ", 32'(occupancy), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("after_branch_pc", fetch_pc, 32'h0000_0100);

        // Grant withheld for five cycles.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("stall_addr", instr_addr, 32'h0000_0104);

        // PC wrap at the top of the address space.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("wrap_addr", instr_addr, 32'h0000_0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Back-to-back branches: the later target wins.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        #1;
        checkOutput("b2b_addr", instr_addr, 32'h0000_0300);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Random traffic with occasional redirects.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 31) == 0), $urandom);
        end

        // Reset in the middle of a granted transfer.
        instr_gnt = 1'b1;
        rstz      = 1'b1;
        #1;
        checkReset();
        @(negedge clk);
        rstz    = 1'b0;
        modelPc = 32'h0;
        qPc.delete();
        qIr.delete();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/kronos_fetch_queue.md
Name: kronos_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the Kronos RV32I pipeline; successor to the single-entry fetch stage.
- Generates sequential instruction-bus requests into a DEPTH-entry prefetch queue of {pc, ir} pairs, and presents them to decode over a valid/ready handshake.
- Adds real branch redirection: a branch flushes the queue and restarts fetch at the target.

Parameters:
- DEPTH, 2, prefetch queue entries; must be a power of two, >=2.
- BOOT_ADDR, 32'h0000_0000, PC loaded at reset.
- PC_INC, 4, byte increment per fetched instruction.

Ports:
- clk  in  1  core clock.
- rstz  in  1  reset; asynchronous, active-high.
- instr_addr  out  32  fetch address; always equals the internal pc.
- instr_data  in  32  instruction word; valid in the cycle where instr_gnt=1.
- instr_req  out  1  fetch request.
- instr_gnt  in  1  grant; a transfer completes on instr_req && instr_gnt.
- branch  in  1  redirect strobe, one cycle.
- branch_target  in  32  redirect PC; bits[1:0] are forced to 0.
- fetch_pc  out  32  PC of the head entry.
- fetch_ir  out  32  instruction of the head entry.
- pipe_out_vld  out  1  head entry valid.
- pipe_out_rdy  in  1  decode accepts the head entry.
- occupancy  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - pc = BOOT_ADDR; queue empty; occupancy = 0.
  - pipe_out_vld = 0; instr_req = 0; fetch_pc = 0; fetch_ir = 0.
- Storage: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits plus an occupancy counter.
  - Pointers wrap modulo DEPTH.
  - full = (occupancy == DEPTH); empty = (occupancy == 0).
- instr_req = !full && !branch. Computed from registered state plus branch only; there is no combinational path from pipe_out_rdy.
- instr_addr = pc, held stable while instr_req=1 && instr_gnt=0.
- Push on instr_req && instr_gnt: write {pc, instr_data} at wr_ptr; pc <= pc + PC_INC (32-bit, wraps at 2^32).
- Pop on pipe_out_vld && pipe_out_rdy: rd_ptr advances.
- pipe_out_vld = !empty. fetch_pc/fetch_ir are read from rd_ptr and held stable while pipe_out_vld && !pipe_out_rdy.
- Simultaneous push and pop: occupancy unchanged; both pointers advance.
- Latency: instruction granted in cycle N appears on the outputs in cycle N+1 (bypass macro off).
- Branch (highest priority):
  - On cycle with branch=1, any gnt in that cycle is discarded and any pop is ignored.
  - Next cycle: queue empty, occupancy = 0, pipe_out_vld = 0, pc = {branch_target[31:2], 2'b00}.
  - instr_req resumes that same next cycle.
- Branch while full: flush still applies.
- Back-to-back branches: the last one wins.
- Full with pipe_out_rdy=0: instr_req stays low; no overflow is possible.
- Pop while empty: ignored.
- Reset mid-transfer: the outstanding gnt is ignored, because instr_req is already 0.

Optional Feature:
- Macro: KRONOS_FETCH_BYPASS_EN.
- When defined: if the queue is empty and a push occurs without branch, the incoming {pc, instr_data} is driven on fetch_pc/fetch_ir with pipe_out_vld=1 in the same cycle.
  - If pipe_out_rdy=1 as well, the entry is consumed without being written (0-cycle latency).
  - Otherwise it is written normally.
- When undefined: fixed 1-cycle gnt-to-vld latency, and outputs come purely from registers.

Test Plan:
- Reset release, gnt tied 1, rdy tied 1 -> instr_addr 0x0,0x4,0x8,...; fetch_pc follows one cycle behind (same cycle with bypass); occupancy <= 1.
- DEPTH=2, rdy=0, gnt=1 -> two pushes (pc 0x0, 0x4), then instr_req=0, occupancy=2, fetch_pc=0x0 held stable; raising rdy drains in order 0x0, 0x4.
- Queue holding 2 entries, branch=1 with target 0x103 and gnt=1 in the same cycle -> next cycle occupancy=0, pipe_out_vld=0, instr_addr=0x100; the granted word is never presented.
- gnt held low for 5 cycles with req=1 -> instr_addr constant, no push, occupancy unchanged.
- pc=0xFFFF_FFFC granted -> next instr_addr=0x0000_0000 (wrap).
- Random gnt/rdy, 1000 cycles, scoreboard -> output PCs strictly sequential between branches, no loss or duplication, occupancy never exceeds DEPTH.
